// File: rtl/fifo_wr_packer.sv
// Packs IN_BITS lanes into {last, count, data} async-FIFO entries; idle partial words flush after FLUSH_CYCLES.
// Latency: 1 cycle from completing lane to p_write_en; a full FIFO with a loaded holding register stalls s_ready.
module fifo_wr_packer #(
    parameter int IN_BITS      = 8,
    parameter int LANES        = 4,
    parameter int FLUSH_CYCLES = 16,
    localparam int CNT_W       = $clog2(LANES) + 1,
    localparam int OUT_BITS    = 1 + CNT_W + LANES * IN_BITS
) (
    input  logic                write_clk,
    input  logic                write_rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [IN_BITS-1:0]  s_data,
    input  logic                s_last,
    output logic                p_write_en,
    output logic [OUT_BITS-1:0] p_write_data,
    input  logic                p_write_full,
    output logic                o_busy,
    output logic [15:0]         o_word_count
);

    localparam int IDX_W = $clog2(LANES);
    localparam int DAT_W = LANES * IN_BITS;
    localparam int TMR_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);
    localparam logic [TMR_W-1:0] FLUSH_T  = TMR_W'(FLUSH_CYCLES);

    if (LANES < 2 || (LANES & (LANES - 1)) != 0) begin : g_lanes_check
        $fatal(1, "fifo_wr_packer: LANES must be a power of two and at least 2");
    end

    logic [IDX_W-1:0]    idx;
    logic [TMR_W-1:0]    timer;
    logic [DAT_W-1:0]    acc_dat;
    logic                hold_valid;
    logic [OUT_BITS-1:0] hold_dat;
    logic [15:0]         word_count;

    logic                accept;
    logic                drain;
    logic                hold_free;
    logic                complete;
    logic                flush;
    logic [DAT_W-1:0]    acc_merged;
    logic [OUT_BITS-1:0] complete_word;
    logic [OUT_BITS-1:0] flush_word;

    assign s_ready      = !hold_valid || !p_write_full;
    assign drain        = hold_valid && !p_write_full;
    assign p_write_en   = drain;
    assign p_write_data = hold_dat;
    assign o_busy       = (idx != '0) || hold_valid;
    assign o_word_count = word_count;

    assign accept    = s_valid && s_ready;
    assign hold_free = !hold_valid || drain;
    assign complete  = accept && ((idx == LAST_IDX) || s_last);

    // An accepted lane always wins over the flush, so the two never coincide.
    assign flush = (FLUSH_CYCLES != 0) && !accept && (idx != '0)
                   && (timer == FLUSH_T) && hold_free;

    always_comb begin
        acc_merged = acc_dat;
        acc_merged[idx * IN_BITS +: IN_BITS] = s_data;
    end

    assign complete_word = {s_last, CNT_W'(idx) + CNT_W'(1), acc_merged};
    assign flush_word    = {1'b0, CNT_W'(idx), acc_dat};

    // Accumulator: unused lanes stay zero because it is cleared whenever a word leaves.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            idx     <= '0;
            acc_dat <= '0;
        end else if (accept) begin
            if (complete) begin
                idx     <= '0;
                acc_dat <= '0;
            end else begin
                idx     <= idx + IDX_W'(1);
                acc_dat <= acc_merged;
            end
        end else if (flush) begin
            idx     <= '0;
            acc_dat <= '0;
        end
    end

    // Idle timer saturates at FLUSH_T so a blocked flush fires as soon as the holding register frees.
    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            timer <= '0;
        end else if (accept || flush || (idx == '0)) begin
            timer <= '0;
        end else if (timer != FLUSH_T) begin
            timer <= timer + TMR_W'(1);
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            hold_valid <= 1'b0;
            hold_dat   <= '0;
        end else if (complete) begin
            hold_valid <= 1'b1;
            hold_dat   <= complete_word;
        end else if (flush) begin
            hold_valid <= 1'b1;
            hold_dat   <= flush_word;
        end else if (drain) begin
            hold_valid <= 1'b0;
        end
    end

    always_ff @(posedge write_clk or negedge write_rst_n) begin
        if (!write_rst_n) begin
            word_count <= '0;
        end else if (drain && (word_count != 16'hFFFF)) begin
            word_count <= word_count + 16'd1;
        end
    end

endmodule

// File: tb/tb_fifo_wr_packer.sv
// Directed bench for fifo_wr_packer with default parameters (8-bit lanes, 4 lanes, 16-cycle flush).
module tb_fifo_wr_packer;

    logic        write_clk    = 1'b0;
    logic        write_rst_n  = 1'b1;
    logic        s_valid      = 1'b0;
    logic        s_ready;
    logic [7:0]  s_data       = 8'h00;
    logic        s_last       = 1'b0;
    logic        p_write_en;
    logic [35:0] p_write_data;
    logic        p_write_full = 1'b0;
    logic        o_busy;
    logic [15:0] o_word_count;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    fifo_wr_packer #(
        .IN_BITS      (8),
        .LANES        (4),
        .FLUSH_CYCLES (16)
    ) dut (
        .write_clk    (write_clk),
        .write_rst_n  (write_rst_n),
        .s_valid      (s_valid),
        .s_ready      (s_ready),
        .s_data       (s_data),
        .s_last       (s_last),
        .p_write_en   (p_write_en),
        .p_write_data (p_write_data),
        .p_write_full (p_write_full),
        .o_busy       (o_busy),
        .o_word_count (o_word_count)
    );

    always #5 write_clk = ~write_clk;

    always @(posedge write_clk) begin
        if (p_write_en === 1'b1) wr_cnt <= wr_cnt + 1;
    end

    // Present one lane and let one rising edge take it; returns on the following falling edge.
    task automatic send_lane(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        @(negedge write_clk);
    endtask

    task automatic go_idle();
        s_valid = 1'b0;
        s_last  = 1'b0;
        s_data  = 8'h00;
    endtask

    task automatic test_reset();
        #2 write_rst_n = 1'b0;
        #1;
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL reset_en: got %b want 0", p_write_en); end
        checks++; if (p_write_data !== 36'h0) begin errors++; $display("FAIL reset_data: got %h want 0", p_write_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        checks++; if (o_word_count !== 16'h0) begin errors++; $display("FAIL reset_count: got %0d want 0", o_word_count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b want 1", s_ready); end
        @(negedge write_clk);
        @(negedge write_clk);
        write_rst_n = 1'b1;
        @(negedge write_clk);
    endtask

    task automatic test_full_word();
        logic [35:0] exp;
        exp = {1'b1, 3'd4, 32'h44332211};
        send_lane(8'h11, 1'b0);
        send_lane(8'h22, 1'b0);
        send_lane(8'h33, 1'b0);
        send_lane(8'h44, 1'b1);
        go_idle();
        #1;
        checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL full_word_en: got %b want 1", p_write_en); end
        checks++; if (p_write_data !== exp) begin errors++; $display("FAIL full_word_data: got %h want %h", p_write_data, exp); end
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL full_word_busy: got %b want 1", o_busy); end
        @(negedge write_clk);
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL full_word_en_after: got %b want 0", p_write_en); end
        checks++; if (o_word_count !== 16'd1) begin errors++; $display("FAIL full_word_count: got %0d want 1", o_word_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL full_word_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_short_packet();
        logic [35:0] exp;
        exp = {1'b1, 3'd2, 32'h0000BBAA};
        send_lane(8'hAA, 1'b0);
        send_lane(8'hBB, 1'b1);
        go_idle();
        #1;
        checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL short_en: got %b want 1", p_write_en); end
        checks++; if (p_write_data !== exp) begin errors++; $display("FAIL short_data: got %h want %h", p_write_data, exp); end
        @(negedge write_clk);
        checks++; if (o_word_count !== 16'd2) begin errors++; $display("FAIL short_count: got %0d want 2", o_word_count); end
    endtask

    task automatic test_flush();
        logic [35:0] exp;
        exp = {1'b0, 3'd1, 32'h0000005A};
        send_lane(8'h5A, 1'b0);
        go_idle();
        #1;
        checks++; if (o_busy !== 1'b1) begin errors++; $display("FAIL flush_busy: got %b want 1", o_busy); end
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL flush_idle_en: got %b want 0", p_write_en); end
        repeat (16) @(negedge write_clk);
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL flush_early: got %b want 0", p_write_en); end
        @(negedge write_clk);
        checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL flush_en: got %b want 1", p_write_en); end
        checks++; if (p_write_data !== exp) begin errors++; $display("FAIL flush_data: got %h want %h", p_write_data, exp); end
        @(negedge write_clk);
        checks++; if (o_word_count !== 16'd3) begin errors++; $display("FAIL flush_count: got %0d want 3", o_word_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL flush_busy_after: got %b want 0", o_busy); end
    endtask

    task automatic test_backpressure();
        logic [35:0] exp1;
        logic [35:0] exp2;
        int          base;
        exp1 = {1'b0, 3'd4, 32'h04030201};
        exp2 = {1'b1, 3'd4, 32'h08070605};
        base = wr_cnt;
        p_write_full = 1'b1;
        send_lane(8'h01, 1'b0);
        send_lane(8'h02, 1'b0);
        send_lane(8'h03, 1'b0);
        send_lane(8'h04, 1'b0);
        s_valid = 1'b1;
        s_data  = 8'h05;
        s_last  = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b want 0", s_ready); end
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL bp_en_held: got %b want 0", p_write_en); end
        checks++; if (p_write_data !== exp1) begin errors++; $display("FAIL bp_hold_data: got %h want %h", p_write_data, exp1); end
        repeat (3) @(negedge write_clk);
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall: got %b want 0", s_ready); end
        checks++; if (p_write_data !== exp1) begin errors++; $display("FAIL bp_hold_stable: got %h want %h", p_write_data, exp1); end
        p_write_full = 1'b0;
        #1;
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_release: got %b want 1", s_ready); end
        checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL bp_en_release: got %b want 1", p_write_en); end
        @(negedge write_clk);
        send_lane(8'h06, 1'b0);
        send_lane(8'h07, 1'b0);
        send_lane(8'h08, 1'b1);
        go_idle();
        #1;
        checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL bp_en_word2: got %b want 1", p_write_en); end
        checks++; if (p_write_data !== exp2) begin errors++; $display("FAIL bp_data_word2: got %h want %h", p_write_data, exp2); end
        @(negedge write_clk);
        checks++; if (wr_cnt - base !== 2) begin errors++; $display("FAIL bp_writes: got %0d want 2", wr_cnt - base); end
        checks++; if (o_word_count !== 16'd5) begin errors++; $display("FAIL bp_count: got %0d want 5", o_word_count); end
    endtask

    task automatic test_reset_mid();
        logic [35:0] exp;
        exp = {1'b0, 3'd4, 32'hD4D3D2D1};
        send_lane(8'hC1, 1'b0);
        send_lane(8'hC2, 1'b0);
        send_lane(8'hC3, 1'b0);
        go_idle();
        #1 write_rst_n = 1'b0;
        #1;
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL rmid_en: got %b want 0", p_write_en); end
        checks++; if (p_write_data !== 36'h0) begin errors++; $display("FAIL rmid_data: got %h want 0", p_write_data); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL rmid_busy: got %b want 0", o_busy); end
        checks++; if (o_word_count !== 16'h0) begin errors++; $display("FAIL rmid_count: got %0d want 0", o_word_count); end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL rmid_ready: got %b want 1", s_ready); end
        @(negedge write_clk);
        write_rst_n = 1'b1;
        send_lane(8'hD1, 1'b0);
        send_lane(8'hD2, 1'b0);
        send_lane(8'hD3, 1'b0);
        send_lane(8'hD4, 1'b0);
        go_idle();
        #1;
        checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL rmid_word_en: got %b want 1", p_write_en); end
        checks++; if (p_write_data !== exp) begin errors++; $display("FAIL rmid_word_data: got %h want %h", p_write_data, exp); end
        @(negedge write_clk);
        checks++; if (o_word_count !== 16'd1) begin errors++; $display("FAIL rmid_word_count: got %0d want 1", o_word_count); end
    endtask

    task automatic test_back_to_back();
        logic [35:0] exp;
        int          k;
        for (int i = 0; i < 12; i++) begin
            send_lane(8'(i), 1'b0);
            #1;
            if (i % 4 == 3) begin
                k   = i / 4;
                exp = {1'b0, 3'd4, 8'(4 * k + 3), 8'(4 * k + 2), 8'(4 * k + 1), 8'(4 * k)};
                checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL stream_en lane %0d: got %b want 1", i, p_write_en); end
                checks++; if (p_write_data !== exp) begin errors++; $display("FAIL stream_data lane %0d: got %h want %h", i, p_write_data, exp); end
            end else begin
                checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL stream_gap lane %0d: got %b want 0", i, p_write_en); end
            end
        end
        go_idle();
        @(negedge write_clk);
        checks++; if (o_word_count !== 16'd4) begin errors++; $display("FAIL stream_count: got %0d want 4", o_word_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL stream_busy: got %b want 0", o_busy); end
        // Single-lane packets complete every cycle while the previous one drains.
        for (int i = 0; i < 4; i++) begin
            send_lane(8'hE0 + 8'(i), 1'b1);
            #1;
            exp = {1'b1, 3'd1, 24'h0, 8'hE0 + 8'(i)};
            checks++; if (p_write_en !== 1'b1) begin errors++; $display("FAIL b2b_en pkt %0d: got %b want 1", i, p_write_en); end
            checks++; if (p_write_data !== exp) begin errors++; $display("FAIL b2b_data pkt %0d: got %h want %h", i, p_write_data, exp); end
        end
        go_idle();
        @(negedge write_clk);
        checks++; if (p_write_en !== 1'b0) begin errors++; $display("FAIL b2b_en_end: got %b want 0", p_write_en); end
        checks++; if (o_word_count !== 16'd8) begin errors++; $display("FAIL b2b_count: got %0d want 8", o_word_count); end
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL b2b_busy: got %b want 0", o_busy); end
    endtask

    initial begin
        test_reset();
        test_full_word();
        test_short_packet();
        test_flush();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
